// File: rtl/mux_slot_scheduler_if.sv
// Bus between the four requesters and the slot scheduler that owns the shared output bit.
// Signalling: req is a level held while a requester wants the output; rel is a one-cycle
// pulse honoured only for the granted index; gnt/sel/y_en/busy/timeout are registered.
interface mux_slot_scheduler_if;
  logic       ena;
  logic [3:0] req;
  logic [3:0] rel;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y_en;
  logic       busy;
  logic       timeout;

  modport master (
    output ena, req, rel,
    input  gnt, sel, y_en, busy, timeout
  );

  modport slave (
    input  ena, req, rel,
    output gnt, sel, y_en, busy, timeout
  );
endinterface

// File: rtl/mux_slot_scheduler.sv
// Round-robin time-slot scheduler for a 4:1 shared output: bounded grants of at most
// SLOT_CYCLES cycles, separated by a single turnaround (GAP) cycle.
module mux_slot_scheduler #(
  parameter int unsigned SLOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_slot_scheduler_if.slave   bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SLOT_CYCLES - 1);

  state_t           r_state, w_nxt_state;
  logic [1:0]       r_ptr, w_nxt_ptr;
  logic [1:0]       r_idx, w_nxt_idx;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [3:0]       r_gnt, w_nxt_gnt;
  logic [1:0]       r_sel, w_nxt_sel;
  logic             r_y_en, w_nxt_y_en;
  logic             r_busy, w_nxt_busy;
  logic             r_timeout, w_nxt_timeout;

  logic [1:0]       w_win;
  logic [1:0]       w_cand;
  logic             w_found;
  logic             w_any;
  logic             w_end_normal;

  // Search starts at r_ptr; in GAP r_ptr already points past the previous owner.
  always_comb begin
    w_win   = r_ptr;
    w_cand  = r_ptr;
    w_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_cand = r_ptr + 2'(i);
      if (!w_found && bus.req[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_any        = |bus.req;
  assign w_end_normal = bus.rel[r_idx] | ~bus.req[r_idx];

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_ptr     = r_ptr;
    w_nxt_idx     = r_idx;
    w_nxt_cnt     = r_cnt;
    w_nxt_gnt     = r_gnt;
    w_nxt_sel     = r_sel;
    w_nxt_y_en    = r_y_en;
    w_nxt_busy    = r_busy;
    w_nxt_timeout = 1'b0;

    unique case (r_state)
      S_IDLE, S_GAP: begin
        if (w_any) begin
          w_nxt_state = S_GRANT;
          w_nxt_idx   = w_win;
          w_nxt_cnt   = CNT_LOAD;
          w_nxt_gnt   = 4'b0001 << w_win;
          w_nxt_sel   = w_win;
          w_nxt_y_en  = 1'b1;
          w_nxt_busy  = 1'b1;
        end else begin
          w_nxt_state = S_IDLE;
          w_nxt_gnt   = 4'b0000;
          w_nxt_y_en  = 1'b0;
          w_nxt_busy  = 1'b0;
        end
      end
      S_GRANT: begin
        // Release wins over expiry, so a coincident rel never reports a timeout.
        if (w_end_normal || (r_cnt == '0)) begin
          w_nxt_state   = S_GAP;
          w_nxt_ptr     = r_idx + 2'd1;
          w_nxt_gnt     = 4'b0000;
          w_nxt_y_en    = 1'b0;
          w_nxt_busy    = 1'b1;
          w_nxt_timeout = ~w_end_normal;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_gnt   = 4'b0000;
        w_nxt_y_en  = 1'b0;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_y_en    <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (bus.ena) begin
      r_state   <= w_nxt_state;
      r_ptr     <= w_nxt_ptr;
      r_idx     <= w_nxt_idx;
      r_cnt     <= w_nxt_cnt;
      r_gnt     <= w_nxt_gnt;
      r_sel     <= w_nxt_sel;
      r_y_en    <= w_nxt_y_en;
      r_busy    <= w_nxt_busy;
      r_timeout <= w_nxt_timeout;
    end else begin
      r_timeout <= 1'b0;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.sel     = r_sel;
  assign bus.y_en    = r_y_en;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;
  assign o_dbg_state = r_state;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
  a_y_en_match  : assert property (@(posedge clk) disable iff (rst) r_y_en == (|r_gnt));
  a_sel_match   : assert property (@(posedge clk) disable iff (rst) r_y_en |-> r_gnt[r_sel]);

endmodule

// File: tb/tb_mux_slot_scheduler.sv
// Bench for mux_slot_scheduler: directed scenarios plus random traffic, each checked
// against a slot-level reference model of the arbitration rules.
module tb_mux_slot_scheduler;

  localparam int SLOT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  logic [8:0] obs;
  int         total = 0;
  int         bad   = 0;
  logic [1:0] exp_q[$];

  mux_slot_scheduler_if bus();

  mux_slot_scheduler #(.SLOT_CYCLES(SLOT), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: owner (-1 = none), cycles the owner has held the output so far,
  // whether the turnaround cycle is showing, the rotating search start and last select.
  int         m_owner = -1;
  int         m_used  = 0;
  bit         m_gap   = 1'b0;
  int         m_ptr   = 0;
  logic [1:0] m_sel   = 2'd0;
  bit         m_tmo   = 1'b0;

  task automatic model_edge();
    if (rst) begin
      m_owner = -1; m_used = 0; m_gap = 1'b0; m_ptr = 0; m_sel = 2'd0; m_tmo = 1'b0;
    end else if (!bus.ena) begin
      m_tmo = 1'b0;
    end else if (m_owner >= 0) begin
      m_tmo = 1'b0;
      if (bus.rel[m_owner] || !bus.req[m_owner] || m_used == SLOT) begin
        m_tmo   = !(bus.rel[m_owner] || !bus.req[m_owner]);
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_used++;
      end
    end else begin
      m_tmo = 1'b0;
      m_gap = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && bus.req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
      if (m_owner >= 0) begin
        m_used = 1;
        m_sel  = 2'(m_owner);
      end
    end
  endtask

  function automatic logic [8:0] exp_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    return {g, m_sel, (m_owner >= 0), (m_owner >= 0) || m_gap, m_tmo};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.req = 4'b0; bus.rel = 4'b0; bus.ena = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.ena = 1'b1; bus.req = 4'b0; bus.rel = 4'b0;
    repeat (2) step();
    obs = {bus.gnt, bus.sel, bus.y_en, bus.busy, bus.timeout};
    total++;
    if (obs !== 9'b0) begin bad++; $display("FAIL reset_vals got=%b exp=%b", obs, 9'b0); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      obs = {bus.gnt, bus.sel, bus.y_en, bus.busy, bus.timeout};
      total++;
      if (obs !== 9'b0) begin bad++; $display("FAIL idle_quiet cyc=%0d got=%b exp=%b", i, obs, 9'b0); end
    end
  endtask

  task automatic test_timeout();
    do_reset(2);
    bus.req = 4'b0100;
    for (int i = 0; i < SLOT; i++) begin
      step();
      total++;
      if (bus.gnt !== 4'b0100 || bus.sel !== 2'b10 || bus.timeout !== 1'b0) begin
        bad++; $display("FAIL timeout_grant cyc=%0d gnt=%b sel=%b tmo=%b exp gnt=0100 sel=10 tmo=0", i, bus.gnt, bus.sel, bus.timeout);
      end
    end
    step();
    total++;
    if (bus.gnt !== 4'b0 || bus.y_en !== 1'b0 || bus.busy !== 1'b1 || bus.timeout !== 1'b1) begin
      bad++; $display("FAIL timeout_gap gnt=%b y_en=%b busy=%b tmo=%b exp 0000 0 1 1", bus.gnt, bus.y_en, bus.busy, bus.timeout);
    end
    step();
    total++;
    if (bus.gnt !== 4'b0100 || bus.timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_regrant gnt=%b tmo=%b exp 0100 0", bus.gnt, bus.timeout);
    end
    obs = {bus.gnt, bus.sel, bus.y_en, bus.busy, bus.timeout};
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL timeout_model got=%b exp=%b", obs, exp_vec()); end
  endtask

  task automatic test_round_robin();
    logic       prev_y;
    logic [1:0] want;
    do_reset(2);
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.req = 4'b1111;
    prev_y  = 1'b0;
    for (int i = 0; i < 5 * (SLOT + 1); i++) begin
      step();
      obs = {bus.gnt, bus.sel, bus.y_en, bus.busy, bus.timeout};
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL rr_model cyc=%0d got=%b exp=%b", i, obs, exp_vec()); end
      if (bus.y_en && !prev_y) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        total++;
        if (bus.sel !== want || bus.gnt !== (4'b0001 << want)) begin
          bad++; $display("FAIL rr_order cyc=%0d sel=%b gnt=%b exp sel=%b", i, bus.sel, bus.gnt, want);
        end
      end
      prev_y = bus.y_en;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rr_count left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_early_release();
    do_reset(2);
    bus.req = 4'b0011;
    repeat (2) step();
    bus.rel = 4'b0001;
    step();
    bus.rel = 4'b0000;
    total++;
    if (bus.gnt !== 4'b0 || bus.timeout !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL rel_end gnt=%b tmo=%b busy=%b exp 0000 0 1", bus.gnt, bus.timeout, bus.busy);
    end
    step();
    bus.rel = 4'b1000;
    step();
    bus.rel = 4'b0000;
    total++;
    if (bus.gnt !== 4'b0010 || bus.sel !== 2'b01) begin
      bad++; $display("FAIL rel_other gnt=%b sel=%b exp 0010 01", bus.gnt, bus.sel);
    end
    obs = {bus.gnt, bus.sel, bus.y_en, bus.busy, bus.timeout};
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL rel_model got=%b exp=%b", obs, exp_vec()); end
  endtask

  task automatic test_coincident();
    do_reset(2);
    bus.req = 4'b0001;
    repeat (SLOT) step();
    bus.rel = 4'b0001;
    step();
    bus.rel = 4'b0000;
    total++;
    if (bus.gnt !== 4'b0 || bus.timeout !== 1'b0) begin
      bad++; $display("FAIL coincident gnt=%b tmo=%b exp 0000 0", bus.gnt, bus.timeout);
    end
  endtask

  task automatic test_ena_freeze();
    do_reset(2);
    bus.req = 4'b0001;
    repeat (2) step();
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.gnt !== 4'b0001 || bus.sel !== 2'b00 || bus.y_en !== 1'b1) begin
        bad++; $display("FAIL ena_hold cyc=%0d gnt=%b sel=%b y_en=%b exp 0001 00 1", i, bus.gnt, bus.sel, bus.y_en);
      end
    end
    bus.ena = 1'b1;
    repeat (2) step();
    total++;
    if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL ena_resume gnt=%b exp 0001", bus.gnt); end
    step();
    total++;
    if (bus.gnt !== 4'b0 || bus.timeout !== 1'b1) begin
      bad++; $display("FAIL ena_expire gnt=%b tmo=%b exp 0000 1", bus.gnt, bus.timeout);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset(2);
    bus.req = 4'b0010;
    repeat (SLOT + 3) step();
    rst = 1'b1;
    step();
    obs = {bus.gnt, bus.sel, bus.y_en, bus.busy, bus.timeout};
    total++;
    if (obs !== 9'b0) begin bad++; $display("FAIL rst_mid got=%b exp=%b", obs, 9'b0); end
    rst = 1'b0;
    bus.req = 4'b1111;
    step();
    total++;
    if (bus.gnt !== 4'b0001 || bus.sel !== 2'b00) begin
      bad++; $display("FAIL rst_ptr gnt=%b sel=%b exp 0001 00", bus.gnt, bus.sel);
    end
  endtask

  task automatic test_random();
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) bus.req[b] = ~bus.req[b];
      bus.rel = ($urandom_range(0, 3) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      bus.ena = ($urandom_range(0, 9) != 0);
      rst     = ($urandom_range(0, 99) == 0);
      step();
      obs = {bus.gnt, bus.sel, bus.y_en, bus.busy, bus.timeout};
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL rand_model cyc=%0d got=%b exp=%b", i, obs, exp_vec()); end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.ena = 1'b1;
    bus.req = 4'b0;
    bus.rel = 4'b0;
    test_reset();
    test_timeout();
    test_round_robin();
    test_early_release();
    test_coincident();
    test_ena_freeze();
    test_reset_mid_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
